// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller: state encoding,
// overlay screen codes and the default game dimensions.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_WIN_PAUSE,
      ST_LOSS_PAUSE,
      ST_GAME_OVER,
      ST_GAME_WON
   } gameState_t;

   localparam logic [2:0] SCREEN_TITLE     = 3'd0;
   localparam logic [2:0] SCREEN_PLAY      = 3'd1;
   localparam logic [2:0] SCREEN_LEVEL_WON = 3'd2;
   localparam logic [2:0] SCREEN_LIFE_LOST = 3'd3;
   localparam logic [2:0] SCREEN_GAME_OVER = 3'd4;
   localparam logic [2:0] SCREEN_GAME_WON  = 3'd5;

   localparam int DEFAULT_NUM_LIVES       = 3;
   localparam int DEFAULT_NUM_LEVELS      = 4;
   localparam int DEFAULT_GIFTS_PER_LEVEL = 5;
   localparam int DEFAULT_PAUSE_FRAMES    = 60;

endpackage

// File: rtl/frame_event_qualifier.sv
// Turns a level-sensitive collision input into at most one single-clk event
// per video frame, taken on the rising edge of the input.
module frame_event_qualifier (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic hit,
   output logic hitEvent
);

   logic hitPrev;
   logic frameUsed;

   // A new frame re-arms the qualifier in the same clk, so an edge that
   // coincides with startOfFrame still counts.
   assign hitEvent = hit & ~hitPrev & (~frameUsed | startOfFrame);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hitPrev   <= 1'b0;
         frameUsed <= 1'b0;
      end else begin
         hitPrev <= hit;
         if (hitEvent)
            frameUsed <= 1'b1;
         else if (startOfFrame)
            frameUsed <= 1'b0;
      end
   end

endmodule

// File: rtl/game_flow_fsm.sv
// Game flow controller: title, level load, play, win/loss pause screens and
// end-of-game screens, with lives, level and gift bookkeeping.
module game_flow_fsm
   import game_pkg::*;
#(
   parameter int NUM_LIVES       = DEFAULT_NUM_LIVES,
   parameter int NUM_LEVELS      = DEFAULT_NUM_LEVELS,
   parameter int GIFTS_PER_LEVEL = DEFAULT_GIFTS_PER_LEVEL,
   parameter int PAUSE_FRAMES    = DEFAULT_PAUSE_FRAMES
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       startKey,
   input  logic       giftHit,
   input  logic       victoryHit,
   input  logic       lossHit,
   output logic       gameRun,
   output logic       levelLoad,
   output logic [1:0] level,
   output logic [1:0] livesLeft,
   output logic [3:0] giftsLeft,
   output logic       giftClear,
   output logic [2:0] screenSel
);

   localparam logic [1:0] LIVES_INIT  = 2'(NUM_LIVES);
   localparam logic [1:0] LAST_LEVEL  = 2'(NUM_LEVELS - 1);
   localparam logic [3:0] GIFTS_INIT  = 4'(GIFTS_PER_LEVEL);
   localparam logic [7:0] PAUSE_LIMIT = 8'(PAUSE_FRAMES);

   gameState_t state;
   logic [7:0] pauseCnt;
   logic       startPrev;
   logic       startEdge;
   logic       pauseDone;
   logic       giftEvent;
   logic       victoryEvent;
   logic       lossEvent;

   frame_event_qualifier giftQual (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .hit          (giftHit),
      .hitEvent     (giftEvent)
   );

   frame_event_qualifier victoryQual (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .hit          (victoryHit),
      .hitEvent     (victoryEvent)
   );

   frame_event_qualifier lossQual (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .hit          (lossHit),
      .hitEvent     (lossEvent)
   );

   assign startEdge = startKey & ~startPrev;
   assign pauseDone = (pauseCnt == PAUSE_LIMIT);
   assign giftClear = (giftsLeft == 4'd0);

   // Outputs are set on the transition clk so they always match the state
   // being entered; levelLoad defaults low and is raised only on LOAD entry.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= ST_IDLE;
         level     <= 2'd0;
         livesLeft <= LIVES_INIT;
         giftsLeft <= GIFTS_INIT;
         pauseCnt  <= 8'd0;
         startPrev <= 1'b0;
         gameRun   <= 1'b0;
         levelLoad <= 1'b0;
         screenSel <= SCREEN_TITLE;
      end else begin
         startPrev <= startKey;
         levelLoad <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (startEdge) begin
                  state     <= ST_LOAD;
                  level     <= 2'd0;
                  livesLeft <= LIVES_INIT;
                  giftsLeft <= GIFTS_INIT;
                  levelLoad <= 1'b1;
                  screenSel <= SCREEN_PLAY;
               end
            end
            ST_LOAD: begin
               state     <= ST_PLAY;
               gameRun   <= 1'b1;
               screenSel <= SCREEN_PLAY;
            end
            ST_PLAY: begin
               if (giftEvent && !giftClear)
                  giftsLeft <= giftsLeft - 4'd1;
               // Loss wins over a simultaneous victory.
               if (lossEvent) begin
                  state     <= ST_LOSS_PAUSE;
                  livesLeft <= (livesLeft != 2'd0) ? livesLeft - 2'd1 : 2'd0;
                  pauseCnt  <= 8'd0;
                  gameRun   <= 1'b0;
                  screenSel <= SCREEN_LIFE_LOST;
               end else if (victoryEvent && giftClear) begin
                  state     <= ST_WIN_PAUSE;
                  pauseCnt  <= 8'd0;
                  gameRun   <= 1'b0;
                  screenSel <= SCREEN_LEVEL_WON;
               end
            end
            ST_WIN_PAUSE: begin
               if (pauseDone) begin
                  if (level == LAST_LEVEL) begin
                     state     <= ST_GAME_WON;
                     screenSel <= SCREEN_GAME_WON;
                  end else begin
                     state     <= ST_LOAD;
                     level     <= level + 2'd1;
                     giftsLeft <= GIFTS_INIT;
                     levelLoad <= 1'b1;
                     screenSel <= SCREEN_PLAY;
                  end
               end else if (startOfFrame) begin
                  pauseCnt <= pauseCnt + 8'd1;
               end
            end
            ST_LOSS_PAUSE: begin
               if (pauseDone) begin
                  if (livesLeft == 2'd0) begin
                     state     <= ST_GAME_OVER;
                     screenSel <= SCREEN_GAME_OVER;
                  end else begin
                     state     <= ST_LOAD;
                     giftsLeft <= GIFTS_INIT;
                     levelLoad <= 1'b1;
                     screenSel <= SCREEN_PLAY;
                  end
               end else if (startOfFrame) begin
                  pauseCnt <= pauseCnt + 8'd1;
               end
            end
            ST_GAME_OVER, ST_GAME_WON: begin
               if (startEdge) begin
                  state     <= ST_IDLE;
                  screenSel <= SCREEN_TITLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               gameRun   <= 1'b0;
               screenSel <= SCREEN_TITLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Scoreboard bench for game_flow_fsm: every output change is popped from an
// expectation queue filled by the stimulus process.
module tb_game_flow_fsm;

   localparam int PAUSE = 60;

   logic       clk = 1'b0;
   logic       resetN;
   logic       startOfFrame;
   logic       startKey;
   logic       giftHit;
   logic       victoryHit;
   logic       lossHit;
   logic       gameRun;
   logic       levelLoad;
   logic [1:0] level;
   logic [1:0] livesLeft;
   logic [3:0] giftsLeft;
   logic       giftClear;
   logic [2:0] screenSel;

   typedef struct {
      logic [13:0] snap;
      string       tag;
   } expEntry_t;

   expEntry_t expQ[$];
   int checks = 0;
   int errors = 0;

   game_flow_fsm dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .startKey     (startKey),
      .giftHit      (giftHit),
      .victoryHit   (victoryHit),
      .lossHit      (lossHit),
      .gameRun      (gameRun),
      .levelLoad    (levelLoad),
      .level        (level),
      .livesLeft    (livesLeft),
      .giftsLeft    (giftsLeft),
      .giftClear    (giftClear),
      .screenSel    (screenSel)
   );

   always #5 clk = ~clk;

   // Snapshot layout: screenSel, gameRun, levelLoad, level, livesLeft, giftsLeft, giftClear
   function automatic logic [13:0] mk(input int scr, input int run, input int load,
                                      input int lvl, input int lives, input int gifts);
      return {3'(scr), 1'(run), 1'(load), 2'(lvl), 2'(lives), 4'(gifts), (gifts == 0)};
   endfunction

   function automatic string fmt(input logic [13:0] s);
      return $sformatf("scr=%0d run=%0d load=%0d lvl=%0d lives=%0d gifts=%0d clr=%0d",
                       s[13:11], s[10], s[9], s[8:7], s[6:5], s[4:1], s[0]);
   endfunction

   task automatic expectSnap(input logic [13:0] s, input string tag);
      expEntry_t e;
      e.snap = s;
      e.tag  = tag;
      expQ.push_back(e);
   endtask

   // Monitor: any change of the output tuple must match the next expectation.
   logic [13:0] prevSnap;
   bit          firstSample = 1'b1;
   always @(negedge clk) begin
      logic [13:0] cur;
      expEntry_t   e;
      cur = {screenSel, gameRun, levelLoad, level, livesLeft, giftsLeft, giftClear};
      if (firstSample || cur !== prevSnap) begin
         firstSample = 1'b0;
         prevSnap = cur;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_change: got %s, required no change", fmt(cur));
         end else begin
            e = expQ.pop_front();
            if (cur !== e.snap) begin
               errors++;
               $display("[TB] FAIL %s: got %s, required %s", e.tag, fmt(cur), fmt(e.snap));
            end
         end
      end
   end

   task automatic expectPending(input int n, input string tag);
      checks++;
      if (expQ.size() != n) begin
         errors++;
         $display("[TB] FAIL %s: pending=%0d required %0d", tag, expQ.size(), n);
      end
   endtask

   task automatic waitDrain(input int budget, input string tag);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s_timeout: pending=%0d required 0", tag, expQ.size());
         expQ.delete();
      end
   endtask

   // One frame: startOfFrame plus optional hits for one clk, then one idle clk.
   task automatic applyStimulus(input bit g, input bit v, input bit l);
      startOfFrame = 1'b1;
      giftHit      = g;
      victoryHit   = v;
      lossHit      = l;
      @(negedge clk);
      startOfFrame = 1'b0;
      giftHit      = 1'b0;
      victoryHit   = 1'b0;
      lossHit      = 1'b0;
      @(negedge clk);
   endtask

   task automatic pressStart(input int hold);
      startKey = 1'b1;
      repeat (hold) @(negedge clk);
      startKey = 1'b0;
      @(negedge clk);
   endtask

   // Runs a full pause; stray hits on frame 5 must be ignored.
   task automatic checkOutput(input int pendBefore, input string tag);
      for (int i = 1; i <= PAUSE; i++) begin
         applyStimulus(i == 5, i == 5, i == 5);
         if (i == PAUSE - 1) begin
            #1;
            expectPending(pendBefore, {tag, "_not_early"});
         end
      end
      @(posedge clk);
      #1;
      expectPending(pendBefore - 1, {tag, "_exit_on_time"});
      @(negedge clk);
      waitDrain(10, tag);
   endtask

   task automatic collectGifts(input int lvl, input int lives);
      for (int g = 4; g >= 0; g--) begin
         expectSnap(mk(1, 1, 0, lvl, lives, g), $sformatf("gift_l%0d_to%0d", lvl, g));
         applyStimulus(1'b1, 1'b0, 1'b0);
         waitDrain(10, "gift");
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      resetN       = 1'b0;
      startKey     = 1'b0;
      startOfFrame = 1'b0;
      giftHit      = 1'b0;
      victoryHit   = 1'b0;
      lossHit      = 1'b0;
      expectSnap(mk(0, 0, 0, 0, 3, 5), "reset_values");
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);

      // Start with the key held across IDLE->LOAD->PLAY
      expectSnap(mk(1, 0, 1, 0, 3, 5), "start_load");
      expectSnap(mk(1, 1, 0, 0, 3, 5), "start_play");
      pressStart(4);
      waitDrain(10, "start");

      // Gift held 10 clks, then a second edge in the same frame
      expectSnap(mk(1, 1, 0, 0, 3, 4), "held_gift");
      giftHit = 1'b1;
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      repeat (9) @(negedge clk);
      giftHit = 1'b0;
      @(negedge clk);
      giftHit = 1'b1;
      @(negedge clk);
      giftHit = 1'b0;
      repeat (3) @(negedge clk);
      waitDrain(10, "held_gift");

      for (int g = 3; g >= 2; g--) begin
         expectSnap(mk(1, 1, 0, 0, 3, g), $sformatf("gift_to%0d", g));
         applyStimulus(1'b1, 1'b0, 1'b0);
         waitDrain(10, "gift");
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      for (int g = 1; g >= 0; g--) begin
         expectSnap(mk(1, 1, 0, 0, 3, g), $sformatf("gift_to%0d", g));
         applyStimulus(1'b1, 1'b0, 1'b0);
         waitDrain(10, "gift");
      end
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      expectSnap(mk(2, 0, 0, 0, 3, 0), "win_pause_l0");
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitDrain(10, "win_l0");
      expectSnap(mk(1, 0, 1, 1, 3, 5), "load_l1");
      expectSnap(mk(1, 1, 0, 1, 3, 5), "play_l1");
      checkOutput(2, "win_pause0");

      // Loss and victory together with giftClear=1
      collectGifts(1, 3);
      expectSnap(mk(3, 0, 0, 1, 2, 0), "loss_beats_victory");
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitDrain(10, "loss1");
      expectSnap(mk(1, 0, 1, 1, 2, 5), "reload_after_loss1");
      expectSnap(mk(1, 1, 0, 1, 2, 5), "play_after_loss1");
      checkOutput(2, "loss_pause1");

      // Loss with a simultaneous gift still counts the gift
      expectSnap(mk(3, 0, 0, 1, 1, 4), "loss_with_gift");
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitDrain(10, "loss2");
      expectSnap(mk(1, 0, 1, 1, 1, 5), "reload_after_loss2");
      expectSnap(mk(1, 1, 0, 1, 1, 5), "play_after_loss2");
      checkOutput(2, "loss_pause2");

      expectSnap(mk(3, 0, 0, 1, 0, 5), "last_life_lost");
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitDrain(10, "loss3");
      expectSnap(mk(4, 0, 0, 1, 0, 5), "game_over");
      checkOutput(1, "loss_pause3");
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      expectSnap(mk(0, 0, 0, 1, 0, 5), "over_to_idle");
      pressStart(2);
      waitDrain(10, "over_to_idle");

      // Second game: clear all four levels
      expectSnap(mk(1, 0, 1, 0, 3, 5), "game2_load");
      expectSnap(mk(1, 1, 0, 0, 3, 5), "game2_play");
      pressStart(1);
      waitDrain(10, "game2_start");
      for (int lv = 0; lv < 4; lv++) begin
         collectGifts(lv, 3);
         expectSnap(mk(2, 0, 0, lv, 3, 0), $sformatf("win_pause_l%0d", lv));
         applyStimulus(1'b0, 1'b1, 1'b0);
         waitDrain(10, "win");
         if (lv < 3) begin
            expectSnap(mk(1, 0, 1, lv + 1, 3, 5), $sformatf("load_l%0d", lv + 1));
            expectSnap(mk(1, 1, 0, lv + 1, 3, 5), $sformatf("play_l%0d", lv + 1));
            checkOutput(2, "win_pause");
         end else begin
            expectSnap(mk(5, 0, 0, 3, 3, 0), "game_won");
            checkOutput(1, "final_win_pause");
         end
      end
      expectSnap(mk(0, 0, 0, 3, 3, 0), "won_to_idle");
      pressStart(1);
      waitDrain(10, "won_to_idle");

      // Reset in the middle of WIN_PAUSE
      expectSnap(mk(1, 0, 1, 0, 3, 5), "game3_load");
      expectSnap(mk(1, 1, 0, 0, 3, 5), "game3_play");
      pressStart(1);
      waitDrain(10, "game3_start");
      collectGifts(0, 3);
      expectSnap(mk(2, 0, 0, 0, 3, 0), "game3_win_pause");
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitDrain(10, "game3_win");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      expectSnap(mk(0, 0, 0, 0, 3, 5), "mid_game_reset");
      #2;
      resetN = 1'b0;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      repeat (10) @(negedge clk);
      waitDrain(5, "mid_game_reset");
      expectSnap(mk(1, 0, 1, 0, 3, 5), "post_reset_load");
      expectSnap(mk(1, 1, 0, 0, 3, 5), "post_reset_play");
      pressStart(1);
      waitDrain(10, "post_reset_start");

      repeat (5) @(negedge clk);
      expectPending(0, "final_queue_empty");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_flow_fsm.md
GAME_FLOW_FSM -- requirements
Module: game_flow_fsm

Interface
REQ-001 Parameter NUM_LIVES, default 3, lives granted at game start (1..3).
REQ-002 Parameter NUM_LEVELS, default 4, levels per game (1..4).
REQ-003 Parameter GIFTS_PER_LEVEL, default 5, gifts to collect before the hole opens (1..15).
REQ-004 Parameter PAUSE_FRAMES, default 60, frames spent in win/loss pause screens (1..255).
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-clk pulse per video frame.
REQ-008 startKey  in  1  level-sensitive start button, already synchronised.
REQ-009 giftHit  in  1  ball overlapping a gift tile; may stay high many clks.
REQ-010 victoryHit  in  1  ball overlapping hole tile; may stay high many clks.
REQ-011 lossHit  in  1  out-of-map or timer expiry; may stay high many clks.
REQ-012 gameRun  out  1  high only in PLAY; enables ball motion and the level timer.
REQ-013 levelLoad  out  1  one-clk pulse: reload map, ball position and timer.
REQ-014 level  out  2  current level index, 0-based.
REQ-015 livesLeft  out  2  remaining lives.
REQ-016 giftsLeft  out  4  gifts remaining in the current level.
REQ-017 giftClear  out  1  high when giftsLeft == 0.
REQ-018 screenSel  out  3  overlay select: 0 title, 1 play, 2 level won, 3 life lost, 4 game over, 5 game won.

Function
REQ-019 States: IDLE, LOAD, PLAY, WIN_PAUSE, LOSS_PAUSE, GAME_OVER, GAME_WON; one-hot or binary encoding is free.
REQ-020 IDLE: on a startKey rising edge, go to LOAD; level=0; livesLeft=NUM_LIVES.
REQ-021 LOAD lasts exactly 1 clk: levelLoad=1, giftsLeft=GIFTS_PER_LEVEL; next state PLAY.
REQ-022 Each hit input is qualified to at most one event per frame. An event is the rising edge of the input. The per-frame flag clears on startOfFrame; startOfFrame clearing and an event in the same clk yields the event.
REQ-023 PLAY, gift event: giftsLeft decrements by 1 and saturates at 0.
REQ-024 PLAY, loss event: go to LOSS_PAUSE; livesLeft decrements by 1 on the transition clk.
REQ-025 PLAY, victory event with giftClear=1: go to WIN_PAUSE. With giftClear=0 the event is ignored.
REQ-026 Simultaneous loss and victory events in one clk: loss has priority. A simultaneous gift event is still counted.
REQ-027 Hit events outside PLAY are ignored and never change counters.
REQ-028 Pause counter: 8 bits, cleared on entry to either pause state, increments on each startOfFrame. The state exits on the clk after the count reaches PAUSE_FRAMES.
REQ-029 WIN_PAUSE exit: if level==NUM_LEVELS-1, go to GAME_WON; otherwise level+1 and go to LOAD.
REQ-030 LOSS_PAUSE exit: if livesLeft==0, go to GAME_OVER; otherwise go to LOAD with the same level.
REQ-031 GAME_OVER/GAME_WON: on a startKey rising edge, go to IDLE.
REQ-032 startKey rising-edge detection uses a registered previous value. Holding the key through IDLE→LOAD produces no second start.
REQ-033 All outputs are registered or decoded from registered state; no combinational input-to-output path.

Reset
REQ-034 Asynchronous reset: state=IDLE, level=0, livesLeft=NUM_LIVES, giftsLeft=GIFTS_PER_LEVEL, pause counter=0, all event flags=0, edge registers=0, gameRun=0, levelLoad=0, screenSel=0.
REQ-035 Reset asserted mid-game aborts immediately with no levelLoad pulse; the first clk after release is IDLE.

Structure
REQ-036 Shared package game_pkg holds the state enum, the screenSel codes and the default parameter values.
REQ-037 One sub-module, frame_event_qualifier (rising edge plus one event per frame), instantiated three times for gift, victory and loss.

Verification
REQ-038 Reset, then startKey pulse → one levelLoad clk, then PLAY; level=0, livesLeft=3, giftsLeft=5, screenSel=1.
REQ-039 giftHit held high 10 clks in one frame → giftsLeft 5→4 only. Five separate gift events → giftsLeft=0, giftClear=1; a 6th event leaves it at 0.
REQ-040 victoryHit with giftsLeft=2 → stays in PLAY. With giftsLeft=0 → WIN_PAUSE. After exactly 60 startOfFrame pulses → LOAD, level=1, giftsLeft=5.
REQ-041 lossHit and victoryHit in the same clk with giftClear=1 → LOSS_PAUSE, livesLeft 3→2. After the pause → LOAD with level unchanged.
REQ-042 Three loss events → GAME_OVER (screenSel=4); startKey → IDLE. Winning level 3 → GAME_WON (screenSel=5).
REQ-043 resetN asserted during WIN_PAUSE → IDLE with all REQ-034 values, and no levelLoad pulse.
